switch_debouncer: RTL and testbench

Eight-channel synchronizer and debouncer for the board slide switches. It sits directly upstream of the 8-input AND/broadcast stage: its `sw_out[0:7]` drives that stage's `a[0:7]`, so the combinational logic only ever sees clean, clock-aligned levels. It also flags each debounced transition with a one-cycle pulse and a per-bit mask.

---
 rtl/switch_debouncer.sv | 63 ++++++
 tb/tb_switch_debouncer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// Eight-channel two-flop synchronizer and counter debouncer for board slide switches.
// Produces clean registered levels plus a one-cycle change pulse and per-bit change mask.
module switch_debouncer #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:WIDTH-1] sw_in,
  output logic [0:WIDTH-1] sw_out,
  output logic             changed,
  output logic [0:WIDTH-1] changed_mask
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [0:WIDTH-1] s1_r;
  logic [0:WIDTH-1] s2_r;
  logic [CNT_W-1:0] cnt_r     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt_s [WIDTH];
  logic [0:WIDTH-1] flip_s;

  // Per-channel next count and flip decision; a return to the current level restarts the count.
  always_comb begin
    for (int i = 0; i < int'(WIDTH); i++) begin
      flip_s[i]    = 1'b0;
      cnt_nxt_s[i] = {CNT_W{1'b0}};
      if (s2_r[i] == sw_out[i]) begin
        cnt_nxt_s[i] = {CNT_W{1'b0}};
      end else if (cnt_r[i] == CNT_MAX) begin
        flip_s[i]    = 1'b1;
        cnt_nxt_s[i] = {CNT_W{1'b0}};
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
      end
    end
  end

  // Synchronizer, counters and registered outputs; reset discards any partial count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r         <= {WIDTH{1'b0}};
      s2_r         <= {WIDTH{1'b0}};
      sw_out       <= {WIDTH{1'b0}};
      changed_mask <= {WIDTH{1'b0}};
      changed      <= 1'b0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      s1_r         <= sw_in;
      s2_r         <= s1_r;
      sw_out       <= sw_out ^ flip_s;
      changed_mask <= flip_s;
      changed      <= |flip_s;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed self-checking bench for switch_debouncer with DEBOUNCE_CYCLES=4, WIDTH=8.
module tb_switch_debouncer;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [0:W-1] sw_in = 8'h00;
  logic [0:W-1] sw_out;
  logic         changed;
  logic [0:W-1] changed_mask;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  switch_debouncer #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw_in(sw_in),
    .sw_out(sw_out),
    .changed(changed),
    .changed_mask(changed_mask)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] so, input logic ch, input logic [7:0] m);
    check({tag, "_sw_out"}, sw_out, so);
    check({tag, "_changed"}, {7'd0, changed}, {7'd0, ch});
    check({tag, "_mask"}, changed_mask, m);
  endtask

  initial begin
    // 1. asynchronous reset with inputs high, before any clock edge
    sw_in = 8'hFF;
    #2 rst = 1'b1;
    #1;
    check_out("reset_async", 8'h00, 1'b0, 8'h00);
    tick();
    tick();
    check_out("reset_held", 8'h00, 1'b0, 8'h00);
    rst = 1'b0;

    // 2. clean step: input held high through reset is re-debounced, flips on E5
    for (int k = 0; k < 5; k++) begin
      tick();
      check_out("step_wait", 8'h00, 1'b0, 8'h00);
    end
    tick();
    check_out("step_flip", 8'hFF, 1'b1, 8'hFF);
    tick();
    check_out("step_after", 8'hFF, 1'b0, 8'h00);

    // 3. bounce: bit 3 low for 3 cycles never reaches the output
    sw_in[3] = 1'b0;
    tick();
    tick();
    tick();
    sw_in[3] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_out("bounce_hold", 8'hFF, 1'b0, 8'h00);
    end
    sw_in[3] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_out("bounce_wait", 8'hFF, 1'b0, 8'h00);
    end
    tick();
    check_out("bounce_flip", 8'hEF, 1'b1, 8'h10);
    tick();
    check_out("bounce_after", 8'hEF, 1'b0, 8'h00);

    // 4. independent bits: bit 0 stepped at E0, bit 7 at E2
    sw_in[0] = 1'b0;
    tick();
    tick();
    sw_in[7] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_out("indep_wait", 8'hEF, 1'b0, 8'h00);
    end
    tick();
    check_out("indep_flip0", 8'h6F, 1'b1, 8'h80);
    tick();
    check_out("indep_gap", 8'h6F, 1'b0, 8'h00);
    tick();
    check_out("indep_flip7", 8'h6E, 1'b1, 8'h01);
    tick();
    check_out("indep_after", 8'h6E, 1'b0, 8'h00);

    // 5. return exactly on the final count: no flip, counter cleared
    sw_in[3] = 1'b1;
    tick();
    tick();
    tick();
    sw_in[3] = 1'b0;
    tick();
    tick();
    check("final_cnt_full", {6'd0, dut.cnt_r[3]}, 8'd3);
    tick();
    check("final_cnt_clear", {6'd0, dut.cnt_r[3]}, 8'd0);
    check_out("final_noflip", 8'h6E, 1'b0, 8'h00);
    tick();
    check_out("final_after", 8'h6E, 1'b0, 8'h00);

    // 6. reset mid-count, then full latency again with the input unchanged
    sw_in = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      tick();
    end
    check("midrst_cnt_before", {6'd0, dut.cnt_r[0]}, 8'd3);
    check_out("midrst_before", 8'h6E, 1'b0, 8'h00);
    #3 rst = 1'b1;
    #1;
    check_out("midrst_async", 8'h00, 1'b0, 8'h00);
    check("midrst_cnt_clear", {6'd0, dut.cnt_r[0]}, 8'd0);
    #1 rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_out("midrst_wait", 8'h00, 1'b0, 8'h00);
    end
    tick();
    check_out("midrst_flip", 8'hFF, 1'b1, 8'hFF);
    tick();
    check_out("midrst_after", 8'hFF, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
